// File: rtl/fifo_byte_rd_cntr.sv
// Read-side pointer and byte unpacker for the DMA longword FIFO: fetches one longword
// at a time and presents its bytes to the consumer. Optional FIFO_BYTE_XFER_CNT_EN adds xfer_cnt.
module fifo_byte_rd_cntr #(
  parameter int DEPTH_LOG2 = 3,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DEPTH_LOG2:0]   wr_ptr,
  input  logic [31:0]           rd_data,
  input  logic                  byte_req,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic [DEPTH_LOG2:0]   rd_ptr,
  output logic [1:0]            byte_ptr,
  output logic                  last_byte,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   fill
`ifdef FIFO_BYTE_XFER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rd_ptr_nxt, rd_ptr_inc;
  logic [1:0]      byte_ptr_nxt;
  logic [31:0]     hold, hold_nxt;
  logic [7:0]      lane;
  logic            consume;

  // Pointer comparison: the MSB is the wrap bit, so equal low bits mean empty or full.
  assign empty      = (rd_ptr == wr_ptr);
  assign full       = (rd_ptr[DEPTH_LOG2] != wr_ptr[DEPTH_LOG2]) &&
                      (rd_ptr[DEPTH_LOG2-1:0] == wr_ptr[DEPTH_LOG2-1:0]);
  assign fill       = wr_ptr - rd_ptr;
  assign rd_ptr_inc = rd_ptr + PW'(1);

  assign byte_valid = (state == SERVE);
  assign last_byte  = byte_valid && (byte_ptr == 2'd3);
  assign consume    = byte_valid && byte_req;

  always_comb begin
    lane = 8'h00;
    case (byte_ptr)
      2'd0: lane = BIG_ENDIAN ? hold[31:24] : hold[7:0];
      2'd1: lane = BIG_ENDIAN ? hold[23:16] : hold[15:8];
      2'd2: lane = BIG_ENDIAN ? hold[15:8]  : hold[23:16];
      2'd3: lane = BIG_ENDIAN ? hold[7:0]   : hold[31:24];
      default: lane = 8'h00;
    endcase
    byte_out = byte_valid ? lane : 8'h00;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    rd_ptr_nxt   = rd_ptr;
    byte_ptr_nxt = byte_ptr;
    hold_nxt     = hold;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = FETCH;
      end
      FETCH: begin
        hold_nxt     = rd_data;
        byte_ptr_nxt = 2'd0;
        state_nxt    = SERVE;
      end
      SERVE: begin
        if (consume) begin
          if (byte_ptr == 2'd3) begin
            rd_ptr_nxt   = rd_ptr_inc;
            byte_ptr_nxt = 2'd0;
            // Uses wr_ptr as seen at this edge, including a same-cycle writer advance.
            state_nxt    = (rd_ptr_inc != wr_ptr) ? FETCH : IDLE;
          end else begin
            byte_ptr_nxt = byte_ptr + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flush discards any partially consumed longword and wins over a consume.
    if (flush) begin
      state_nxt    = IDLE;
      rd_ptr_nxt   = '0;
      byte_ptr_nxt = 2'd0;
      hold_nxt     = 32'h0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      byte_ptr <= 2'd0;
      // NOTE: the holding register is reset so byte_out is defined from the first cycle.
      hold     <= 32'h0;
    end else begin
      state    <= state_nxt;
      rd_ptr   <= rd_ptr_nxt;
      byte_ptr <= byte_ptr_nxt;
      hold     <= hold_nxt;
    end
  end

`ifdef FIFO_BYTE_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 16'h0000;
    end else if (flush) begin
      xfer_cnt <= 16'h0000;
    end else if (consume && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_byte_rd_cntr.sv
// Directed bench for fifo_byte_rd_cntr: big- and little-endian instances share stimulus;
// checks reset, unpacking order, full/fill, request stalls, flush and a 16-longword wrap drain.
module tb_fifo_byte_rd_cntr;

  logic        clk = 1'b0;
  logic        rst_n, flush, byte_req;
  logic [3:0]  wr_ptr;
  logic [31:0] rd_data, rd_const;
  logic        use_mem;
  logic [7:0]  byte_out, byte_out_le;
  logic        byte_valid, byte_valid_le, last_byte, last_byte_le;
  logic [3:0]  rd_ptr, rd_ptr_le, fill, fill_le;
  logic [1:0]  byte_ptr, byte_ptr_le;
  logic        empty, empty_le, full, full_le;
`ifdef FIFO_BYTE_XFER_CNT_EN
  logic [15:0] xfer_cnt, xfer_cnt_le;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_byte_rd_cntr #(.DEPTH_LOG2(3), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_ptr(wr_ptr), .rd_data(rd_data),
    .byte_req(byte_req), .byte_out(byte_out), .byte_valid(byte_valid), .rd_ptr(rd_ptr),
    .byte_ptr(byte_ptr), .last_byte(last_byte), .empty(empty), .full(full), .fill(fill)
`ifdef FIFO_BYTE_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  fifo_byte_rd_cntr #(.DEPTH_LOG2(3), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_ptr(wr_ptr), .rd_data(rd_data),
    .byte_req(byte_req), .byte_out(byte_out_le), .byte_valid(byte_valid_le), .rd_ptr(rd_ptr_le),
    .byte_ptr(byte_ptr_le), .last_byte(last_byte_le), .empty(empty_le), .full(full_le),
    .fill(fill_le)
`ifdef FIFO_BYTE_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt_le)
`endif
  );

  // RAM model: longword at address p holds bytes p, p+40, p+80, p+C0 (byte 0 first).
  logic [7:0] p8;
  always_comb begin
    p8      = {4'h0, rd_ptr};
    rd_data = use_mem ? {p8, p8 + 8'h40, p8 + 8'h80, p8 + 8'hC0} : rd_const;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   nbytes, bubbles, rd_moves;
  bit   started;
  logic [3:0] prev_rd;
  logic [7:0] exp_b;

  initial begin
    rst_n = 1'b0; flush = 1'b0; byte_req = 1'b0; wr_ptr = 4'd0;
    rd_const = 32'h0; use_mem = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_fill", fill, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_byte_out", byte_out, 0);

    // Single longword, request held high.
    rd_const = 32'h11223344; byte_req = 1'b1; wr_ptr = 4'd1;
    tick();
    check("lat_fetch_valid", byte_valid, 0);
    tick();
    check("lat_valid", byte_valid, 1);
    check("be_b0", byte_out, 8'h11);
    check("le_b0", byte_out_le, 8'h44);
    tick();
    check("be_b1", byte_out, 8'h22);
    check("le_b1", byte_out_le, 8'h33);
    tick();
    check("be_b2", byte_out, 8'h33);
    check("le_b2", byte_out_le, 8'h22);
    check("last_low", last_byte, 0);
    tick();
    check("be_b3", byte_out, 8'h44);
    check("le_b3", byte_out_le, 8'h11);
    check("last_high", last_byte, 1);
    tick();
    check("one_rd_ptr", rd_ptr, 1);
    check("one_empty", empty, 1);
    check("one_valid", byte_valid, 0);
    tick();
    check("one_idle", byte_valid, 0);

    // Flush, then writer fills all 8 longwords.
    byte_req = 1'b0; flush = 1'b1; wr_ptr = 4'd8;
    tick();
    flush = 1'b0;
    check("full_full", full, 1);
    check("full_fill", fill, 8);
    check("full_empty", empty, 0);
    rd_const = 32'hA1B2C3D4; byte_req = 1'b1;
    tick();
    tick();
    check("full_b0", byte_out, 8'hA1);
    tick(); tick(); tick();
    check("full_b3", byte_out, 8'hD4);
    check("full_still", full, 1);
    tick();
    check("after4_full", full, 0);
    check("after4_fill", fill, 7);
    check("after4_rd_ptr", rd_ptr, 1);
    check("after4_valid", byte_valid, 0);

    // Request toggling 1,0,0,1 during SERVE.
    byte_req = 1'b0;
    tick();
    check("tog_valid", byte_valid, 1);
    check("tog_b0", byte_out, 8'hA1);
    byte_req = 1'b1; tick();
    check("tog_ptr1", byte_ptr, 1);
    byte_req = 1'b0; tick();
    check("tog_hold1_ptr", byte_ptr, 1);
    check("tog_hold1_out", byte_out, 8'hB2);
    tick();
    check("tog_hold2_ptr", byte_ptr, 1);
    check("tog_hold2_out", byte_out, 8'hB2);
    byte_req = 1'b1; tick();
    check("tog_ptr2", byte_ptr, 2);
    check("tog_b2", byte_out, 8'hC3);

    // Flush at byte_ptr=2 together with a request.
    flush = 1'b1;
    tick();
    flush = 1'b0; wr_ptr = 4'd0;
    check("flush_byte_ptr", byte_ptr, 0);
    check("flush_rd_ptr", rd_ptr, 0);
    check("flush_valid", byte_valid, 0);
`ifdef FIFO_BYTE_XFER_CNT_EN
    check("flush_xfer", xfer_cnt, 0);
`endif
    tick();
    check("ign_req_ptr", byte_ptr, 0);
    check("ign_req_valid", byte_valid, 0);

    // Drain 16 longwords with the writer staying up to 8 ahead.
    use_mem = 1'b1; wr_ptr = 4'd8; byte_req = 1'b1;
    nbytes = 0; bubbles = 0; rd_moves = 0; started = 1'b0; prev_rd = rd_ptr;
    for (int cyc = 0; cyc < 400 && nbytes < 64; cyc++) begin
      tick();
      if (rd_ptr != prev_rd) rd_moves++;
      prev_rd = rd_ptr;
      if (byte_valid) begin
        started = 1'b1;
        exp_b = 8'(nbytes / 4) + 8'h40 * 8'(nbytes % 4);
        check("drain_byte", byte_out, exp_b);
        nbytes++;
      end else if (started) begin
        bubbles++;
      end
      wr_ptr = 4'((rd_moves + 8 > 16) ? 16 : rd_moves + 8);
    end
    check("drain_count", nbytes, 64);
    check("drain_bubbles", bubbles, 15);
    check("drain_pre_wrap", prev_rd, 15);
    tick();
    check("drain_wrap", rd_ptr, 0);
    check("drain_empty", empty, 1);
    check("drain_valid", byte_valid, 0);
`ifdef FIFO_BYTE_XFER_CNT_EN
    check("drain_xfer", xfer_cnt, 64);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_byte_rd_cntr.md
Name: fifo_byte_rd_cntr

Overview:
This block is the read-side pointer and byte unpacker for the DMA longword FIFO. The write side advances a 3-bit longword counter with a wrap bit. This block tracks the read longword pointer and the byte lane within that longword, and hands bytes one at a time to the SCSI byte-side consumer. It also derives EMPTY, FULL and FILL by comparing the read pointer against the write pointer.

Parameters:
- DEPTH_LOG2, 3: log2 of FIFO depth in longwords. Pointers are DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
- BIG_ENDIAN, 1: 1 means byte 0 = RD_DATA[31:24]. 0 means byte 0 = RD_DATA[7:0].

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous clear of all read-side state.
- WR_PTR  in  DEPTH_LOG2+1  write-side longword pointer, including wrap bit.
- RD_DATA  in  32  FIFO RAM read data at RD_PTR; valid one clock after RD_PTR is stable.
- BYTE_REQ  in  1  consumer accepts BYTE_OUT this cycle.
- BYTE_OUT  out  8  current byte lane of the held longword.
- BYTE_VALID  out  1  BYTE_OUT is valid.
- RD_PTR  out  DEPTH_LOG2+1  read longword pointer; its low bits address the RAM.
- BYTE_PTR  out  2  byte lane currently presented.
- LAST_BYTE  out  1  BYTE_VALID & (BYTE_PTR==3).
- EMPTY  out  1  RD_PTR == WR_PTR (combinational).
- FULL  out  1  MSBs differ and low DEPTH_LOG2 bits are equal (combinational).
- FILL  out  DEPTH_LOG2+1  WR_PTR - RD_PTR, modulo 2^(DEPTH_LOG2+1) (combinational).

Behaviour:
- Reset (RST_ low, asynchronous):
  - state=IDLE, RD_PTR=0, BYTE_PTR=0, holding register=0.
  - BYTE_VALID=0, BYTE_OUT=0.
- State machine, 2-bit encoding: IDLE, FETCH, SERVE.
  - IDLE: BYTE_VALID=0. If !EMPTY, go to FETCH on the next edge.
  - FETCH: one cycle. On the edge leaving FETCH, capture RD_DATA into the holding register, set BYTE_PTR=0, go to SERVE.
  - SERVE: BYTE_VALID=1. BYTE_OUT = the lane selected by BYTE_PTR and BIG_ENDIAN.
- Consume = BYTE_VALID & BYTE_REQ, sampled at the edge.
  - BYTE_PTR<3: BYTE_PTR increments; stay in SERVE.
  - BYTE_PTR==3: RD_PTR increments, wrapping through the MSB; BYTE_PTR=0.
    - Next state is FETCH if the incremented RD_PTR != WR_PTR, otherwise IDLE.
- BYTE_REQ while BYTE_VALID=0 is ignored.
- BYTE_OUT and BYTE_PTR hold while BYTE_REQ is low.
- Latency and throughput:
  - WR_PTR changes before edge N with the FIFO empty → FETCH after edge N → BYTE_VALID=1 after edge N+1.
  - Streaming throughput is 4 bytes per 5 clocks; FETCH is a 1-cycle bubble per longword.
- Pointer arithmetic:
  - RD_PTR increments modulo 2^(DEPTH_LOG2+1), i.e. 7→8 and 15→0 for the default.
  - FILL=8 when FULL. FILL=0 when EMPTY.
- EMPTY/FULL are combinational from the current registers. They reflect an RD_PTR increment the cycle after the consume edge.
- FLUSH:
  - Priority is RST_ > FLUSH > consume.
  - Sets RD_PTR=0, BYTE_PTR=0, state=IDLE, BYTE_VALID=0 on that edge.
  - Any partially consumed longword is discarded.
  - The write side is cleared by the same FLUSH.
- Simultaneous consume of the last byte and a WR_PTR advance: the next-state decision uses the WR_PTR value at that edge.
- WR_PTR overrunning RD_PTR (FILL>8) is a write-side protocol violation; behaviour is unspecified.

Optional Feature:
- Macro: FIFO_BYTE_XFER_CNT_EN.
- When defined:
  - Adds output XFER_CNT[15:0]: count of consumed bytes.
  - Increments on each consume; saturates at 16'hFFFF.
  - Cleared to 0 by RST_ and FLUSH.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, WR_PTR=0 → EMPTY=1, FULL=0, FILL=0, BYTE_VALID=0, RD_PTR=0.
- WR_PTR=1, RD_DATA=32'h11223344, BYTE_REQ held 1:
  - BYTE_VALID rises 2 clocks later.
  - BYTE_OUT sequence is 11,22,33,44.
  - LAST_BYTE is high on the 44 cycle.
  - RD_PTR=1, EMPTY=1, back to IDLE.
- WR_PTR=8 with RD_PTR=0 → FULL=1, FILL=8. After 4 consumes → FULL=0, FILL=7.
- Drain 16 longwords with BYTE_REQ=1 and the writer keeping pace:
  - RD_PTR wraps 15→0.
  - 64 bytes out, with exactly one idle cycle per longword.
  - With the macro on, XFER_CNT=64.
- FLUSH asserted at BYTE_PTR=2 concurrently with BYTE_REQ → BYTE_PTR=0, RD_PTR=0, BYTE_VALID=0 next cycle; no increment of RD_PTR.
- BYTE_REQ toggling 1,0,0,1 during SERVE → BYTE_OUT and BYTE_PTR hold during the 0 cycles. BIG_ENDIAN=0 run on 32'h11223344 gives 44,33,22,11.
